// File: rtl/fetch_if.sv
// Fetch-side bundle: instruction-memory port, decode feedback, IF/ID register outputs.
// dbg_pc_ld/dbg_pc_val redirect the PC to an arbitrary 32-bit value; tie low in normal use.
interface fetch_if;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic        imem_rvalid;
  logic [0:31] imem_rdata;
  logic        ID_stall;
  logic        ID_br_ctrl;
  logic [0:15] ID_imm_addr;
  logic [0:31] IF_ID_inst;
  logic        IF_ID_valid;
  logic [0:31] IF_ID_pc;
  logic        dbg_pc_ld;
  logic [0:31] dbg_pc_val;

  modport master (
    output imem_req, imem_addr, IF_ID_inst, IF_ID_valid, IF_ID_pc,
    input  imem_rvalid, imem_rdata, ID_stall, ID_br_ctrl, ID_imm_addr, dbg_pc_ld, dbg_pc_val
  );

  modport slave (
    input  imem_req, imem_addr, IF_ID_inst, IF_ID_valid, IF_ID_pc,
    output imem_rvalid, imem_rdata, ID_stall, ID_br_ctrl, ID_imm_addr, dbg_pc_ld, dbg_pc_val
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, result lands in IF/ID on the edge sampling rvalid.
// ID_stall holds IF/ID; a response arriving under stall parks in a one-entry buffer (FULL).
module fetch_unit (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]  state;
  logic [0:31] pc;
  logic [0:31] buf_inst;
  logic [0:31] if_id_inst;
  logic [0:31] if_id_pc;
  logic        if_id_valid;
  logic        adv;
  logic        redirect;
  logic [0:31] redirect_pc;

  // The debug load behaves exactly like a branch, only with a full-width target.
  always_comb begin
    adv         = !bus.ID_stall;
    redirect    = bus.ID_br_ctrl | bus.dbg_pc_ld;
    redirect_pc = bus.ID_br_ctrl ? {16'b0, bus.ID_imm_addr} : bus.dbg_pc_val;
  end

  assign bus.imem_req    = reset && (state == FETCH) && !redirect;
  assign bus.imem_addr   = pc;
  assign bus.IF_ID_inst  = if_id_inst;
  assign bus.IF_ID_pc    = if_id_pc;
  assign bus.IF_ID_valid = if_id_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= '0;
      buf_inst    <= '0;
      if_id_inst  <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      pc          <= redirect_pc;
      buf_inst    <= '0;
      // A request still in flight must be swallowed before the target is fetched.
      if ((state == WAIT || state == DROP) && !bus.imem_rvalid)
        state <= DROP;
      else
        state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          state <= WAIT;
          if (adv)
            if_id_valid <= 1'b0;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            if (adv) begin
              if_id_inst  <= bus.imem_rdata;
              if_id_pc    <= pc;
              if_id_valid <= 1'b1;
              pc          <= pc + 32'd4;
              state       <= FETCH;
            end else begin
              buf_inst <= bus.imem_rdata;
              state    <= FULL;
            end
          end else if (adv) begin
            if_id_valid <= 1'b0;
          end
        end
        FULL: begin
          if (adv) begin
            if_id_inst  <= buf_inst;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            pc          <= pc + 32'd4;
            state       <= FETCH;
          end
        end
        DROP: begin
          if (bus.imem_rvalid)
            state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written reset corners, and a random run
// checked against a program-order model (next expected PC, memory word = hash of address).
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fetch_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          br;
    logic [15:0] imm;
    bit          rv;
    logic [31:0] rdata;
    bit          ld;
    logic [31:0] ldv;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit st, bit br, logic [15:0] imm, bit rv,
                              logic [31:0] rd, bit ld, logic [31:0] ldv, bit er,
                              logic [31:0] ea, bit ev, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = rst; v.stall = st; v.br = br; v.imm = imm; v.rv = rv; v.rdata = rd;
    v.ld = ld; v.ldv = ldv; v.e_req = er; v.e_addr = ea; v.e_valid = ev;
    v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ID_stall    = 1'b0;
    bus.ID_br_ctrl  = 1'b0;
    bus.ID_imm_addr = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.dbg_pc_ld   = 1'b0;
    bus.dbg_pc_val  = '0;
  endtask

  // Leaves time at posedge+1 of the first cycle after release.
  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Entered at posedge+1: drive, check request mid-cycle, check IF/ID after the edge.
  task automatic step(input vec_t v, input int id);
    bus.ID_stall    = v.stall;
    bus.ID_br_ctrl  = v.br;
    bus.ID_imm_addr = v.imm;
    bus.imem_rvalid = v.rv;
    bus.imem_rdata  = v.rdata;
    bus.dbg_pc_ld   = v.ld;
    bus.dbg_pc_val  = v.ldv;
    #3;
    chk($sformatf("vec%0d imem_req", id), bus.imem_req, v.e_req);
    chk($sformatf("vec%0d imem_addr", id), bus.imem_addr, v.e_addr);
    @(posedge clk);
    #1;
    clear_inputs();
    chk($sformatf("vec%0d IF_ID_valid", id), bus.IF_ID_valid, v.e_valid);
    chk($sformatf("vec%0d IF_ID_pc", id), bus.IF_ID_pc, v.e_pc);
    chk($sformatf("vec%0d IF_ID_inst", id), bus.IF_ID_inst, v.e_inst);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " imem_req"}, bus.imem_req, 0);
    chk({tag, " imem_addr"}, bus.imem_addr, 0);
    chk({tag, " IF_ID_valid"}, bus.IF_ID_valid, 0);
    chk({tag, " IF_ID_pc"}, bus.IF_ID_pc, 0);
    chk({tag, " IF_ID_inst"}, bus.IF_ID_inst, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] next_pc;
    logic [31:0] raddr;
    bit          pend;
    int          cnt;
    int          deliv;
    bit          rv, br_now, st_now;
    logic [15:0] tgt;
    logic        pre_v;
    logic [31:0] pre_pc, pre_inst;

    clear_inputs();

    // 1-cycle memory, three instructions
    tbl.push_back(mk(1,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h0, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,1,32'h11111111,0,32'h0, 0,32'h0, 1,32'h0,32'h11111111));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h4, 0,32'h0,32'h11111111));
    tbl.push_back(mk(0,0,0,16'h0,1,32'h22222222,0,32'h0, 0,32'h4, 1,32'h4,32'h22222222));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h8, 0,32'h4,32'h22222222));
    tbl.push_back(mk(0,0,0,16'h0,1,32'h33333333,0,32'h0, 0,32'h8, 1,32'h8,32'h33333333));
    // response under 3-cycle stall parks in FULL
    tbl.push_back(mk(1,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h0, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,1,32'h12345678,0,32'h0, 0,32'h0, 1,32'h0,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h4, 0,32'h0,32'h12345678));
    tbl.push_back(mk(0,1,0,16'h0,1,32'hAAAA0000,0,32'h0, 0,32'h4, 0,32'h0,32'h12345678));
    tbl.push_back(mk(0,1,0,16'h0,0,32'h0,0,32'h0, 0,32'h4, 0,32'h0,32'h12345678));
    tbl.push_back(mk(0,1,0,16'h0,0,32'h0,0,32'h0, 0,32'h4, 0,32'h0,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 0,32'h4, 1,32'h4,32'hAAAA0000));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h8, 0,32'h4,32'hAAAA0000));
    // branch in WAIT, stale response dropped
    tbl.push_back(mk(1,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h0, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,1,16'h0040,0,32'h0,0,32'h0, 0,32'h0, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 0,32'h40, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,1,32'hDEADBEEF,0,32'h0, 0,32'h40, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h40, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,1,32'h40404040,0,32'h0, 0,32'h40, 1,32'h40,32'h40404040));
    // branch + rvalid + stall in one cycle
    tbl.push_back(mk(1,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h0, 0,32'h0,32'h0));
    tbl.push_back(mk(0,1,1,16'h0100,1,32'hBADBAD00,0,32'h0, 0,32'h0, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h100, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,1,32'h01000100,0,32'h0, 0,32'h100, 1,32'h100,32'h01000100));
    // branch in FETCH gates the request; carry out of the low half
    tbl.push_back(mk(1,0,1,16'hFFFC,0,32'h0,0,32'h0, 0,32'h0, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'hFFFC, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,1,32'hF0F0F0F0,0,32'h0, 0,32'hFFFC, 1,32'hFFFC,32'hF0F0F0F0));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h10000, 0,32'hFFFC,32'hF0F0F0F0));
    tbl.push_back(mk(0,0,0,16'h0,1,32'h10000000,0,32'h0, 0,32'h10000, 1,32'h10000,32'h10000000));
    // 32-bit wrap via the debug load
    tbl.push_back(mk(1,0,0,16'h0,0,32'h0,1,32'hFFFFFFFC, 0,32'h0, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'hFFFFFFFC, 0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0,1,32'h0BADF00D,0,32'h0, 0,32'hFFFFFFFC, 1,32'hFFFFFFFC,32'h0BADF00D));
    tbl.push_back(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h0, 0,32'hFFFFFFFC,32'h0BADF00D));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset();
        #3;
        check_zero_regs: begin
          chk($sformatf("vec%0d reset IF_ID_valid", i), bus.IF_ID_valid, 0);
          chk($sformatf("vec%0d reset IF_ID_pc", i), bus.IF_ID_pc, 0);
        end
        @(posedge clk);
        #1;
        // the cycle just consumed still issued a request to 0; restart cleanly
        do_reset();
      end
      step(tbl[i], i);
    end

    // asynchronous reset while a request is outstanding (WAIT)
    do_reset();
    step(mk(0,0,1,16'h0200,0,32'h0,0,32'h0, 0,32'h0, 0,32'h0,32'h0), 100);
    step(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h200, 0,32'h0,32'h0), 101);
    step(mk(0,0,0,16'h0,1,32'h77777777,0,32'h0, 0,32'h200, 1,32'h200,32'h77777777), 102);
    step(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h204, 0,32'h200,32'h77777777), 103);
    #2 reset = 1'b0;
    #1 check_zero("rst_wait");
    @(posedge clk);
    #1 reset = 1'b1;
    step(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h0, 0,32'h0,32'h0), 104);
    step(mk(0,0,0,16'h0,1,32'h12121212,0,32'h0, 0,32'h0, 1,32'h0,32'h12121212), 105);

    // asynchronous reset while an instruction sits in the buffer (FULL)
    do_reset();
    step(mk(0,0,1,16'h0300,0,32'h0,0,32'h0, 0,32'h0, 0,32'h0,32'h0), 110);
    step(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h300, 0,32'h0,32'h0), 111);
    step(mk(0,0,0,16'h0,1,32'h66666666,0,32'h0, 0,32'h300, 1,32'h300,32'h66666666), 112);
    step(mk(0,1,0,16'h0,0,32'h0,0,32'h0, 1,32'h304, 1,32'h300,32'h66666666), 113);
    step(mk(0,1,0,16'h0,1,32'h55555555,0,32'h0, 0,32'h304, 1,32'h300,32'h66666666), 114);
    #2 reset = 1'b0;
    #1 check_zero("rst_full");
    @(posedge clk);
    #1 reset = 1'b1;
    step(mk(0,0,0,16'h0,0,32'h0,0,32'h0, 1,32'h0, 0,32'h0,32'h0), 115);
    step(mk(0,0,0,16'h0,1,32'h13131313,0,32'h0, 0,32'h0, 1,32'h0,32'h13131313), 116);

    // random run against the program-order model
    do_reset();
    next_pc = 32'h0;
    pend    = 1'b0;
    cnt     = 0;
    raddr   = 32'h0;
    deliv   = 0;
    for (int c = 0; c < 3000; c++) begin
      rv = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          rv   = 1'b1;
          pend = 1'b0;
        end
      end
      br_now = ($urandom_range(0, 99) < 5);
      st_now = ($urandom_range(0, 99) < 30);
      tgt    = 16'($urandom_range(0, 16383) * 4);
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? memf(raddr) : $urandom();
      bus.ID_stall    = st_now;
      bus.ID_br_ctrl  = br_now;
      bus.ID_imm_addr = tgt;
      bus.dbg_pc_ld   = 1'b0;
      #3;
      if (bus.imem_req) begin
        chk("rnd imem_addr", bus.imem_addr, next_pc);
        chk("rnd single_outstanding", 32'(pend), 0);
        pend  = 1'b1;
        cnt   = $urandom_range(1, 4);
        raddr = bus.imem_addr;
      end
      pre_v    = bus.IF_ID_valid;
      pre_pc   = bus.IF_ID_pc;
      pre_inst = bus.IF_ID_inst;
      @(posedge clk);
      #1;
      if (br_now) begin
        chk("rnd flush IF_ID_valid", bus.IF_ID_valid, 0);
        next_pc = {16'b0, tgt};
      end else if (st_now) begin
        chk("rnd hold IF_ID_valid", bus.IF_ID_valid, pre_v);
        chk("rnd hold IF_ID_pc", bus.IF_ID_pc, pre_pc);
        chk("rnd hold IF_ID_inst", bus.IF_ID_inst, pre_inst);
      end else if (bus.IF_ID_valid) begin
        chk("rnd deliver IF_ID_pc", bus.IF_ID_pc, next_pc);
        chk("rnd deliver IF_ID_inst", bus.IF_ID_inst, memf(next_pc));
        next_pc = next_pc + 32'd4;
        deliv++;
      end
    end
    clear_inputs();
    chk("rnd progress", 32'(deliv >= 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
